// File: rtl/ser2par_if.sv
// Word-assembly port bundle for ser2par: qualified serial input side plus assembled word output side.
// The master drives the serial bits; the slave (ser2par) returns words, the strobe and progress.
interface ser2par_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH);

  logic             data_serial;
  logic             data_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_parallel;
  logic             parallel_valid;
  logic [CW-1:0]    bit_count;

  modport master (
    output data_serial, data_valid, frame_start,
    input  data_parallel, parallel_valid, bit_count
  );

  modport slave (
    input  data_serial, data_valid, frame_start,
    output data_parallel, parallel_valid, bit_count
  );
endinterface

// File: rtl/ser2par.sv
// Serial-to-parallel converter: gathers WIDTH qualified bits into a word and strobes it out.
// Counter-based framing, with frame_start forcing the current bit to become bit 0 of a new word.
module ser2par #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     reset_n,
  ser2par_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_reg;
  logic [WIDTH-2:0] shift_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] data_parallel_reg;
  logic             parallel_valid_reg;

  logic [WIDTH-1:0] word_next;
  logic [WIDTH-2:0] shift_next;
  logic [WIDTH-2:0] fresh_next;
  logic             complete;

  // A partial word never exceeds WIDTH-1 bits, so the final bit joins the word straight from the input.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_next  = {shift_reg, bus.data_serial};
      assign shift_next = word_next[WIDTH-2:0];
      assign fresh_next = (WIDTH-1)'(bus.data_serial);
    end else begin : g_lsb
      assign word_next  = {bus.data_serial, shift_reg};
      assign shift_next = word_next[WIDTH-1:1];
      assign fresh_next = (WIDTH-1)'(bus.data_serial) << (WIDTH-2);
    end
  endgenerate

  assign complete = (state_reg == COLLECT) && (count_reg == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      shift_reg          <= '0;
      count_reg          <= '0;
      data_parallel_reg  <= '0;
      parallel_valid_reg <= 1'b0;
    end else begin
      parallel_valid_reg <= 1'b0;
      if (bus.frame_start) begin
        // Realignment drops any partial word silently, even one bit short of completion.
        if (bus.data_valid) begin
          shift_reg <= fresh_next;
          count_reg <= CW'(1);
          state_reg <= COLLECT;
        end else begin
          shift_reg <= '0;
          count_reg <= '0;
          state_reg <= IDLE;
        end
      end else if (bus.data_valid) begin
        if (complete) begin
          data_parallel_reg  <= word_next;
          parallel_valid_reg <= 1'b1;
          shift_reg          <= '0;
          count_reg          <= '0;
          state_reg          <= IDLE;
        end else begin
          shift_reg <= shift_next;
          count_reg <= count_reg + CW'(1);
          state_reg <= COLLECT;
        end
      end
    end
  end

  assign bus.data_parallel  = data_parallel_reg;
  assign bus.parallel_valid = parallel_valid_reg;
  assign bus.bit_count      = count_reg;
endmodule

// File: tb/tb_ser2par.sv
// Bench for ser2par: MSB-first and LSB-first instances share one stimulus stream and are
// checked against a directed table, a queue-based word model, and a loopback serializer.
module tb_ser2par;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ds = 1'b0, dv = 1'b0, fs = 1'b0;

  always #5 clk = ~clk;

  ser2par_if #(.WIDTH(W)) bus_m ();
  ser2par_if #(.WIDTH(W)) bus_l ();

  assign bus_m.data_serial = ds;
  assign bus_m.data_valid  = dv;
  assign bus_m.frame_start = fs;
  assign bus_l.data_serial = ds;
  assign bus_l.data_valid  = dv;
  assign bus_l.frame_start = fs;

  ser2par #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset_n(reset_n), .bus(bus_m.slave));
  ser2par #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(bus_l.slave));

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the current word in arrival order.
  int q[$];
  int m_msb = 0, m_lsb = 0, m_pv = 0;

  typedef struct {
    logic d, v, f;
    int   msb, lsb, pv, bc;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_msb = 0; m_lsb = 0; m_pv = 0;
  endtask

  task automatic model_edge();
    m_pv = 0;
    if (fs) begin
      q.delete();
      if (dv) q.push_back(int'(ds));
    end else if (dv) begin
      q.push_back(int'(ds));
      if (q.size() == W) begin
        m_msb = 0; m_lsb = 0;
        foreach (q[i]) begin
          m_msb += q[i] * (2 ** (W - 1 - i));
          m_lsb += q[i] * (2 ** i);
        end
        m_pv = 1;
        q.delete();
      end
    end
  endtask

  task automatic cycle(input logic d, input logic v, input logic f);
    ds = d; dv = v; fs = f;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " dp_msb"}, int'(bus_m.data_parallel), m_msb);
    chk({tag, " dp_lsb"}, int'(bus_l.data_parallel), m_lsb);
    chk({tag, " pv_msb"}, int'(bus_m.parallel_valid), m_pv);
    chk({tag, " pv_lsb"}, int'(bus_l.parallel_valid), m_pv);
    chk({tag, " bc_msb"}, int'(bus_m.bit_count), q.size());
    chk({tag, " bc_lsb"}, int'(bus_l.bit_count), q.size());
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ds = 1'b0; dv = 1'b0; fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic d, v, f, input int msb, lsb, pv, bc);
    vec_t r;
    r.d = d; r.v = v; r.f = f; r.msb = msb; r.lsb = lsb; r.pv = pv; r.bc = bc;
    vecs.push_back(r);
  endtask

  initial begin
    int strobes;
    logic [W-1:0] word;

    // Directed table: one row per clock, expectations after that edge.
    add(1,1,0, 0,0,0,1);  add(0,1,0, 0,0,0,2);  add(1,1,0, 0,0,0,3);
    add(1,1,0, 'b1011,'b1101,1,0);  add(0,0,0, 'b1011,'b1101,0,0);
    add(0,1,0, 'b1011,'b1101,0,1);  add(1,1,0, 'b1011,'b1101,0,2);
    add(1,0,0, 'b1011,'b1101,0,2);  add(0,0,0, 'b1011,'b1101,0,2);
    add(1,0,0, 'b1011,'b1101,0,2);  add(1,1,0, 'b1011,'b1101,0,3);
    add(0,1,0, 'b0110,'b0110,1,0);
    add(1,1,0, 'b0110,'b0110,0,1);  add(1,1,0, 'b0110,'b0110,0,2);
    add(1,1,0, 'b0110,'b0110,0,3);  add(0,1,1, 'b0110,'b0110,0,1);
    add(0,1,0, 'b0110,'b0110,0,2);  add(1,1,0, 'b0110,'b0110,0,3);
    add(1,1,0, 'b0011,'b1100,1,0);
    add(1,1,0, 'b0011,'b1100,0,1);  add(0,0,1, 'b0011,'b1100,0,0);
    add(1,1,0, 'b0011,'b1100,0,1);  add(0,1,0, 'b0011,'b1100,0,2);

    // T1: reset held while inputs toggle.
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ds = 1'b1; dv = (i % 2 == 0); fs = 1'b0;
      @(posedge clk); #1;
      chk("reset dp", int'(bus_m.data_parallel), 0);
      chk("reset pv", int'(bus_m.parallel_valid), 0);
      chk("reset bc", int'(bus_m.bit_count), 0);
      chk("reset dp_lsb", int'(bus_l.data_parallel), 0);
    end
    reset_n = 1'b1;
    model_reset();

    // T2..T5 from the table.
    foreach (vecs[i]) begin
      cycle(vecs[i].d, vecs[i].v, vecs[i].f);
      chk($sformatf("vec%0d dp_msb", i), int'(bus_m.data_parallel), vecs[i].msb);
      chk($sformatf("vec%0d dp_lsb", i), int'(bus_l.data_parallel), vecs[i].lsb);
      chk($sformatf("vec%0d pv", i), int'(bus_m.parallel_valid), vecs[i].pv);
      chk($sformatf("vec%0d pv_lsb", i), int'(bus_l.parallel_valid), vecs[i].pv);
      chk($sformatf("vec%0d bc", i), int'(bus_m.bit_count), vecs[i].bc);
      if (vecs[i].pv != 0)
        $display("vec%0d word msb=%b lsb=%b", i, bus_m.data_parallel, bus_l.data_parallel);
    end

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      check_model("rand");
      if (m_pv != 0) $display("rand word msb=%b lsb=%b", bus_m.data_parallel, bus_l.data_parallel);
    end

    // T6: par2ser-style loopback of 16 words, continuous valid.
    do_reset();
    strobes = 0;
    for (int w = 0; w < 16; w++) begin
      word = W'($urandom);
      for (int b = W - 1; b >= 0; b--) begin
        cycle(word[b], 1'b1, 1'b0);
        check_model("stream");
        if (bus_m.parallel_valid) strobes++;
        chk("stream pv_phase", int'(bus_m.parallel_valid), (b == 0) ? 1 : 0);
      end
      chk("stream word", int'(bus_m.data_parallel), int'(word));
      $display("stream word %0d sent=%b got=%b", w, word, bus_m.data_parallel);
    end
    chk("stream strobes", strobes, 16);

    // Mid-word async reset, then a clean word.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("pre-reset bc", int'(bus_m.bit_count), 2);
    reset_n = 1'b0;
    #1;
    chk("async dp", int'(bus_m.data_parallel), 0);
    chk("async bc", int'(bus_m.bit_count), 0);
    chk("async pv", int'(bus_m.parallel_valid), 0);
    #1;
    reset_n = 1'b1;
    model_reset();
    word = 4'b1001;
    for (int b = W - 1; b >= 0; b--) begin
      cycle(word[b], 1'b1, 1'b0);
      check_model("post-reset");
    end
    chk("post-reset word", int'(bus_m.data_parallel), int'(word));
    chk("post-reset pv", int'(bus_m.parallel_valid), 1);
    $display("post-reset word got=%b", bus_m.data_parallel);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
